axi_rd_slave: RTL and testbench
===============================

// Module: axi_rd_slave
// PURPOSE
//   AXI4 read-channel responder: the memory-side end of the AR/R interface driven by the fetch path.
//   Accepts one AR request at a time and returns ARLEN+1 R beats with RID echo and RLAST.
//   Beats are read from a simple synchronous memory port. It sits between the core's AXI
//   read master and the simulation/SRAM memory model.
// PARAMETERS
//   ID_W   4               width of ARID/RID
//   BASE   64'h8000_0000   first valid byte address
//   SIZE   64'h0800_0000   valid region size in bytes; legal range is [BASE, BASE+SIZE)
//   LAT    0               extra wait cycles before the first beat of each burst (0..255)
// PORTS
//   clk        in   1     clock, all logic on posedge
//   rst        in   1     asynchronous, active-high reset
//   ARID       in   ID_W  request ID
//   ARADDR     in   64    start byte address
//   ARLEN      in   8     beats-1
//   ARSIZE     in   3     log2 bytes per beat
//   ARBURST    in   2     00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   ARVALID    in   1     request valid
//   ARREADY    out  1     request accept
//   RID        out  ID_W  echoed ARID
//   RDATA      out  64    read data, full aligned dword
//   RRESP      out  2     00 OKAY, 10 SLVERR
//   RLAST      out  1     final beat of burst
//   RVALID     out  1     beat valid
//   RREADY     in   1     master accepts beat
//   mem_ren    out  1     memory read strobe, 1-cycle pulse
//   mem_addr   out  64    memory address, {addr[63:3],3'b0}
//   mem_rdata  in   64    memory data, valid the cycle after mem_ren
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; ARREADY=0; RVALID=0; RLAST=0; RID=0; RDATA=0; RRESP=0;
//     mem_ren=0; mem_addr=0; beat and wait counters=0.
//   Reset dropped mid-burst: the burst is abandoned and no further beats are produced.
//   States:
//     IDLE: ARREADY=1 (registered; first 1 is the cycle after reset release).
//       ARVALID&ARREADY: latch ID, addr, len, size, burst; ARREADY->0; go WAIT with cnt=LAT.
//     WAIT: cnt==0 -> MEM, else cnt--.
//     MEM: mem_ren=1, mem_addr=aligned cur addr; go DATA.
//       Error beats still pulse mem_ren; their data is discarded.
//     DATA: RDATA<=mem_rdata (or 0 on error); RRESP; RLAST=(beat==len); RVALID<=1; go RESP.
//     RESP: hold RID/RDATA/RRESP/RLAST/RVALID stable until RREADY.
//       On RVALID&RREADY:
//         last beat: RVALID->0; go IDLE; ARREADY->1 next cycle.
//         else: beat++; advance addr; go MEM (no LAT on later beats).
//   Latency:
//     AR handshake edge to first RVALID = LAT+3 cycles.
//     R handshake edge to next RVALID = 2 cycles.
//     Single outstanding burst; no AR accepted while busy.
//   Address advance, with B=1<<ARSIZE:
//     FIXED: unchanged.
//     INCR: addr+B, 64-bit wrap.
//     WRAP: boundary W=(len+1)*B; addr=(addr&~(W-1)) | ((addr+B)&(W-1)).
//   SLVERR applies to the whole burst if any of:
//     ARBURST==11;
//     ARSIZE>3;
//     WRAP with len not in {1,3,7,15};
//     WRAP with ARADDR not aligned to B.
//   SLVERR applies per beat if the beat address is outside [BASE, BASE+SIZE).
//   Error beats: RDATA=0, RRESP=10, beat count and RLAST unchanged.
//   Narrow beats return the whole aligned dword; the master selects lanes by address.
//   RVALID never drops without a handshake. Outputs do not change while RVALID=1 and RREADY=0.
// TESTING
//   INCR single: ARADDR=8000_0000, ARLEN=0, ARSIZE=3, ID=5, LAT=0, mem returns A5A5..
//     -> one beat, RID=5, RDATA=A5A5.., RLAST=1, RRESP=00, RVALID 3 cycles after AR handshake.
//   INCR 4x4B from 8000_0004 with RREADY toggling 1,0,1,0
//     -> mem_addr 8000_0000, 8000_0008, 8000_0008, 8000_0010;
//        RLAST on beat 4 only; data held stable through stalls.
//   WRAP len=3, size=3, start 8000_0018
//     -> mem_addr 18, 00, 08, 10 (offsets from 8000_0000); RLAST on the 4th beat.
//   Errors:
//     ARADDR=0000_1000, len=1 -> 2 beats, RRESP=10, RDATA=0, RLAST on the 2nd.
//     ARBURST=11 -> all beats SLVERR.
//   LAT=4, back-to-back ARVALID held high
//     -> ARREADY low until burst done; 2nd AR accepted the cycle after last-beat handshake + 1.
//   Assert rst while RVALID=1 mid-burst -> RVALID=0 immediately; after release ARREADY=1 next cycle.

Source files
------------

// File: rtl/axi_rd_slave.sv
// AXI4 read-channel responder: serves one AR burst at a time, fetching each beat
// from a synchronous memory port whose data returns the cycle after mem_ren.
module axi_rd_slave #(
  parameter int          ID_W = 4,
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter logic [63:0] SIZE = 64'h0800_0000,
  parameter int          LAT  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] ARID,
  input  logic [63:0]     ARADDR,
  input  logic [7:0]      ARLEN,
  input  logic [2:0]      ARSIZE,
  input  logic [1:0]      ARBURST,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [ID_W-1:0] RID,
  output logic [63:0]     RDATA,
  output logic [1:0]      RRESP,
  output logic            RLAST,
  output logic            RVALID,
  input  logic            RREADY,
  output logic            mem_ren,
  output logic [63:0]     mem_addr,
  input  logic [63:0]     mem_rdata
);
  localparam logic [7:0] LAT_C = 8'(LAT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MEM, S_DATA, S_RESP} state_t;
  state_t r_state, w_next;

  logic            r_arready, r_berr, r_rvalid, r_rlast;
  logic [ID_W-1:0] r_id, r_rid;
  logic [63:0]     r_addr, r_rdata;
  logic [7:0]      r_len, r_cnt, r_beat;
  logic [2:0]      r_size;
  logic [1:0]      r_burst, r_rresp;

  logic        w_ar_hs, w_r_hs, w_wrap_len_ok, w_ar_err, w_oor, w_err;
  logic [63:0] w_ar_bytes, w_bytes, w_wmask, w_next_addr;
  logic [64:0] w_lim;

  assign w_ar_hs    = (r_state == S_IDLE) && r_arready && ARVALID;
  assign w_r_hs     = r_rvalid && RREADY;
  assign w_ar_bytes = 64'd1 << ARSIZE;
  assign w_wrap_len_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
  // Malformed requests poison every beat of the burst.
  assign w_ar_err = (ARBURST == 2'b11) || (ARSIZE > 3'd3) ||
                    ((ARBURST == 2'b10) &&
                     (!w_wrap_len_ok || ((ARADDR & (w_ar_bytes - 64'd1)) != 64'd0)));

  assign w_lim = {1'b0, BASE} + {1'b0, SIZE};
  assign w_oor = (r_addr < BASE) || ({1'b0, r_addr} >= w_lim);
  assign w_err = r_berr || w_oor;

  assign w_bytes = 64'd1 << r_size;
  assign w_wmask = (({56'd0, r_len} + 64'd1) << r_size) - 64'd1;

  always_comb begin
    case (r_burst)
      2'b01:   w_next_addr = r_addr + w_bytes;
      2'b10:   w_next_addr = (r_addr & ~w_wmask) | ((r_addr + w_bytes) & w_wmask);
      default: w_next_addr = r_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_ar_hs) w_next = S_WAIT;
      S_WAIT: if (r_cnt == 8'd0) w_next = S_MEM;
      S_MEM:  w_next = S_DATA;
      S_DATA: w_next = S_RESP;
      S_RESP: if (w_r_hs) w_next = r_rlast ? S_IDLE : S_MEM;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arready <= 1'b0;
      r_berr    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_id      <= '0;
      r_rid     <= '0;
      r_addr    <= '0;
      r_rdata   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_rresp   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_id      <= ARID;
            r_addr    <= ARADDR;
            r_len     <= ARLEN;
            r_size    <= ARSIZE;
            r_burst   <= ARBURST;
            r_berr    <= w_ar_err;
            r_cnt     <= LAT_C;
            r_beat    <= 8'd0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        S_WAIT: if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        // mem_rdata answers the MEM-cycle read; error beats discard it.
        S_DATA: begin
          r_rid    <= r_id;
          r_rdata  <= w_err ? 64'd0 : mem_rdata;
          r_rresp  <= w_err ? 2'b10 : 2'b00;
          r_rlast  <= (r_beat == r_len);
          r_rvalid <= 1'b1;
        end
        S_RESP: begin
          if (w_r_hs) begin
            r_rvalid <= 1'b0;
            if (!r_rlast) begin
              r_beat <= r_beat + 8'd1;
              r_addr <= w_next_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ARREADY  = r_arready;
  assign RID      = r_rid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign RLAST    = r_rlast;
  assign RVALID   = r_rvalid;
  assign mem_ren  = (r_state == S_MEM);
  assign mem_addr = mem_ren ? {r_addr[63:3], 3'b000} : 64'd0;
endmodule

// File: tb/tb_axi_rd_slave.sv
// Bench for axi_rd_slave: directed and randomized bursts scored against a
// beat-level reference model with its own memory image.
module tb_axi_rd_slave;
  localparam int          ID_W = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h0800_0000;
  localparam int          LAT  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ID_W-1:0] ARID = '0;
  logic [63:0]     ARADDR = '0;
  logic [7:0]      ARLEN = '0;
  logic [2:0]      ARSIZE = '0;
  logic [1:0]      ARBURST = '0;
  logic            ARVALID = 1'b0;
  logic            ARREADY;
  logic [ID_W-1:0] RID;
  logic [63:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY = 1'b0;
  logic            mem_ren;
  logic [63:0]     mem_addr;
  logic [63:0]     mem_rdata = '0;

  int          n_vec = 0;
  int          n_bad = 0;
  time         t_last_hs = 0;
  logic [63:0] q_maddr[$];

  always #5 clk = ~clk;

  axi_rd_slave #(.ID_W(ID_W), .BASE(BASE), .SIZE(SIZE), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == BASE) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {a[31:0] ^ 32'h1357_9BDF, ~a[31:0]};
  endfunction

  // Synchronous memory image: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= mem_fn(mem_addr);
      q_maddr.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit burst_err(input logic [63:0] a, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] b;
    b = 64'd1 << size;
    if (burst == 2'b11 || size > 3) return 1'b1;
    if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    if (burst == 2'b10 && (a % b) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] step_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] b, w;
    b = 64'd1 << size;
    w = ({56'd0, len} + 64'd1) * b;
    if (burst == 2'b01) return a + b;
    if (burst == 2'b10) return (a & ~(w - 64'd1)) | ((a + b) & (w - 64'd1));
    return a;
  endfunction

  // mode: 0 ready on sight, 1 one stall per beat, 2 ready held early, 3 random stalls
  task automatic do_burst(input logic [ID_W-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int mode,
                          input bit hold, input bit chk_gap);
    logic [63:0] a, exp_d, exp_ma[$];
    logic        berr, e, ar_seen;
    int          n, ns;
    time         t_ref, t_rise;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 100) begin @(negedge clk); n++; end
    if (!ARREADY) begin chk("ar_timeout", 64'd0, 64'd1); ARVALID = 1'b0; return; end
    @(posedge clk);
    t_ref = $time;
    if (chk_gap) chk("b2b_gap", 64'(t_ref - t_last_hs), 64'd20);
    q_maddr.delete();
    @(negedge clk);
    if (!hold) ARVALID = 1'b0;
    a = addr;
    berr = burst_err(addr, len, size, burst);
    ar_seen = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      e = berr || (a < BASE) || (a >= BASE + SIZE);
      exp_ma.push_back({a[63:3], 3'b000});
      exp_d = e ? 64'd0 : mem_fn({a[63:3], 3'b000});
      if (mode == 2) RREADY = 1'b1;
      n = 0;
      while (!RVALID && n < 300) begin
        if (ARREADY) ar_seen = 1'b1;
        @(negedge clk);
        n++;
      end
      if (!RVALID) begin chk("rvalid_timeout", 64'd0, 64'd1); RREADY = 1'b0; return; end
      t_rise = $time - 5;
      chk($sformatf("latency_beat%0d", k), 64'((t_rise - t_ref) / 10), (k == 0) ? 64'(LAT + 3) : 64'd2);
      chk("rid", 64'(RID), 64'(id));
      chk("rdata", RDATA, exp_d);
      chk("rresp", 64'(RRESP), e ? 64'd2 : 64'd0);
      chk("rlast", 64'(RLAST), 64'(k == int'(len)));
      ns = (mode == 1) ? 1 : (mode == 3) ? int'($urandom_range(0, 3)) : 0;
      repeat (ns) begin
        RREADY = 1'b0;
        if (ARREADY) ar_seen = 1'b1;
        @(negedge clk);
        chk("stall_rvalid", 64'(RVALID), 64'd1);
        chk("stall_rdata", RDATA, exp_d);
        chk("stall_rresp", 64'(RRESP), e ? 64'd2 : 64'd0);
        chk("stall_rlast", 64'(RLAST), 64'(k == int'(len)));
      end
      RREADY = 1'b1;
      @(posedge clk);
      t_ref = $time;
      @(negedge clk);
      RREADY = 1'b0;
      a = step_addr(a, len, size, burst);
    end
    t_last_hs = t_ref;
    chk("post_rvalid", 64'(RVALID), 64'd0);
    chk("post_arready", 64'(ARREADY), 64'd0);
    chk("arready_while_busy", 64'(ar_seen), 64'd0);
    chk("mem_reads", 64'(q_maddr.size()), 64'(exp_ma.size()));
    for (int i = 0; i < exp_ma.size() && i < q_maddr.size(); i++)
      chk($sformatf("mem_addr%0d", i), q_maddr[i], exp_ma[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  wl[4];
    logic [1:0]  bu;
    logic [2:0]  sz;
    logic [7:0]  ln;
    logic [63:0] ad;
    int          r, n;
    bit          seen;
    wl = '{8'd1, 8'd3, 8'd7, 8'd15};

    #12;
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_rid", 64'(RID), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arready_after_release", 64'(ARREADY), 64'd1);

    do_burst(4'd5, BASE, 8'd0, 3'd3, 2'b01, 0, 1'b0, 1'b0);
    do_burst(4'd2, BASE + 64'h4, 8'd3, 3'd2, 2'b01, 1, 1'b0, 1'b0);
    do_burst(4'd7, BASE + 64'h18, 8'd3, 3'd3, 2'b10, 3, 1'b0, 1'b0);
    do_burst(4'd1, 64'h1000, 8'd1, 3'd3, 2'b01, 0, 1'b0, 1'b0);
    do_burst(4'd9, BASE + 64'h100, 8'd2, 3'd3, 2'b11, 2, 1'b0, 1'b0);
    do_burst(4'd3, BASE + 64'h200, 8'd2, 3'd3, 2'b01, 2, 1'b1, 1'b0);
    do_burst(4'd3, BASE + 64'h200, 8'd2, 3'd3, 2'b01, 0, 1'b0, 1'b1);
    do_burst(4'd4, BASE + SIZE - 64'h8, 8'd2, 3'd3, 2'b01, 0, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      r  = int'($urandom_range(0, 9));
      bu = (r == 0) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      ln = (bu == 2'b10 && $urandom_range(0, 5) != 0) ? wl[$urandom_range(0, 3)] : 8'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ad = BASE + 64'($urandom_range(0, 4095));
        1:       ad = BASE + SIZE - 64'($urandom_range(1, 64));
        2:       ad = BASE - 64'($urandom_range(1, 48));
        default: ad = {32'd0, $urandom()};
      endcase
      if (bu == 2'b10 && $urandom_range(0, 4) != 0) ad = ad & ~((64'd1 << sz) - 64'd1);
      do_burst(4'($urandom_range(0, 15)), ad, ln, sz, bu, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Reset while a beat is waiting on RREADY.
    @(negedge clk);
    ARID = 4'd6; ARADDR = BASE + 64'h40; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    ARVALID = 1'b0;
    RREADY = 1'b0;
    n = 0;
    while (!RVALID && n < 100) begin @(negedge clk); n++; end
    chk("rvalid_before_reset", 64'(RVALID), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(RVALID), 64'd0);
    chk("midrst_rlast", 64'(RLAST), 64'd0);
    chk("midrst_rdata", RDATA, 64'd0);
    chk("midrst_arready", 64'(ARREADY), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    RREADY = 1'b1;
    @(negedge clk);
    chk("midrst_arready_next", 64'(ARREADY), 64'd1);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (RVALID || mem_ren) seen = 1'b1; end
    RREADY = 1'b0;
    chk("abandoned_no_beats", 64'(seen), 64'd0);
    do_burst(4'd8, BASE + 64'h80, 8'd1, 3'd3, 2'b01, 3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
